// File: rtl/text_box_overlay.sv
// -----------------------------------------------------------------------------
// text_box_overlay
//
// Draws a COLS x ROWS grid of 8x16 font glyphs at (X_POS, Y_POS) on top of
// the incoming VGA stream. Each glyph can be pixel-scaled by 2^SCALE_LOG2 in
// both x and y. Character codes live in an internal text buffer that the
// control logic writes. Glyph rows come from the shared external font ROM,
// which has a 1-cycle synchronous read. All video fields pass through with a
// fixed latency of 4 clocks. Only rgb can be modified on the way through.
//
// After reset the buffer is filled with spaces, one entry per clock, while
// busy is high. During that clear, writes are ignored and the overlay is off.
//
// Ports
//   clk            pixel clock
//   rst            synchronous, active-high reset
//   vga_in_*       hcount/vcount/hsync/vsync/hblnk/vblnk/rgb from the
//                  previous stage
//   vga_out_*      the same fields, delayed 4 clocks, with rgb overlaid
//   wr_en          text buffer write strobe
//   wr_addr        write index = row*COLS + col; out-of-range values are
//                  dropped
//   wr_data        7-bit ASCII code
//   char_addr      font ROM address {code[6:0], line[3:0]}
//   char_pixels    font ROM row, MSB = leftmost pixel, valid 1 clk after
//                  char_addr
//   busy           high while the buffer clear runs
// -----------------------------------------------------------------------------
module text_box_overlay #(
   parameter int          X_POS      = 280,
   parameter int          Y_POS      = 104,
   parameter int          COLS       = 16,
   parameter int          ROWS       = 4,
   parameter int          SCALE_LOG2 = 0,
   parameter logic [11:0] FG_COLOR   = 12'hFFF,
   parameter logic        BG_EN      = 1'b0,
   parameter logic [11:0] BG_COLOR   = 12'h000,
   localparam int         NUM_CHARS  = COLS * ROWS,
   localparam int         AW         = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
   input  logic          clk,
   input  logic          rst,

   input  logic [10:0]   vga_in_hcount,
   input  logic [10:0]   vga_in_vcount,
   input  logic          vga_in_hsync,
   input  logic          vga_in_vsync,
   input  logic          vga_in_hblnk,
   input  logic          vga_in_vblnk,
   input  logic [11:0]   vga_in_rgb,

   output logic [10:0]   vga_out_hcount,
   output logic [10:0]   vga_out_vcount,
   output logic          vga_out_hsync,
   output logic          vga_out_vsync,
   output logic          vga_out_hblnk,
   output logic          vga_out_vblnk,
   output logic [11:0]   vga_out_rgb,

   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [6:0]    wr_data,

   output logic [10:0]   char_addr,
   input  logic [7:0]    char_pixels,

   output logic          busy
);

   localparam int SCALE = 1 << SCALE_LOG2;

   // Box bounds are held in 32 bits so that a box running past the
   // 11-bit coordinate range is clipped instead of wrapping round to 0.
   localparam logic [31:0] X_LO = 32'(X_POS);
   localparam logic [31:0] X_HI = 32'(X_POS + COLS * 8 * SCALE);
   localparam logic [31:0] Y_LO = 32'(Y_POS);
   localparam logic [31:0] Y_HI = 32'(Y_POS + ROWS * 16 * SCALE);

   localparam logic [AW-1:0] LAST_PTR    = AW'(NUM_CHARS - 1);
   localparam logic [AW:0]   NUM_CHARS_W = (AW + 1)'(NUM_CHARS);
   localparam logic [6:0]    SPACE_CODE  = 7'h20;

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_t;

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   state_t        state;
   state_t        state_next;
   logic [AW-1:0] clr_ptr;
   logic [AW-1:0] clr_ptr_next;

   logic          run;
   logic          buf_we;
   logic [AW-1:0] buf_waddr;
   logic [6:0]    buf_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_next;
         clr_ptr <= clr_ptr_next;
      end
   end

   always_comb begin
      state_next   = state;
      clr_ptr_next = clr_ptr;
      case (state)
         CLEAR: begin
            clr_ptr_next = clr_ptr + 1'b1;
            if (clr_ptr == LAST_PTR) begin
               state_next   = RUN;
               clr_ptr_next = '0;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next   = CLEAR;
            clr_ptr_next = '0;
         end
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      run       = 1'b0;
      buf_we    = 1'b0;
      buf_waddr = '0;
      buf_wdata = '0;
      case (state)
         CLEAR: begin
            busy      = 1'b1;
            buf_we    = 1'b1;
            buf_waddr = clr_ptr;
            buf_wdata = SPACE_CODE;
         end
         RUN: begin
            run       = 1'b1;
            buf_we    = wr_en && ({1'b0, wr_addr} < NUM_CHARS_W);
            buf_waddr = wr_addr;
            buf_wdata = wr_data;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Box geometry for the incoming pixel
   // ---------------------------------------------------------------------------
   logic [31:0]   h_ext;
   logic [31:0]   v_ext;
   logic [10:0]   dx;
   logic [10:0]   dy;
   logic [10:0]   col;
   logic [10:0]   row;
   logic [3:0]    line;
   logic [2:0]    xbit;
   logic          in_box;
   logic [AW-1:0] rd_idx;

   always_comb begin
      h_ext  = {21'd0, vga_in_hcount};
      v_ext  = {21'd0, vga_in_vcount};
      in_box = (h_ext >= X_LO) && (h_ext < X_HI) &&
               (v_ext >= Y_LO) && (v_ext < Y_HI);
      dx     = vga_in_hcount - 11'(X_POS);
      dy     = vga_in_vcount - 11'(Y_POS);
      col    = dx >> (3 + SCALE_LOG2);
      row    = dy >> (4 + SCALE_LOG2);
      line   = 4'(dy >> SCALE_LOG2);
      xbit   = 3'(dx >> SCALE_LOG2);
      // Read entry 0 outside the box so that the index never leaves the buffer.
      rd_idx = '0;
      if (in_box) begin
         rd_idx = AW'(({21'd0, row} * 32'(COLS)) + {21'd0, col});
      end
   end

   // ---------------------------------------------------------------------------
   // Text buffer. A read and a write in the same cycle return the old code.
   // ---------------------------------------------------------------------------
   logic [6:0] text_mem [NUM_CHARS];
   logic [6:0] rd_mem;
   logic [6:0] rd_code;

   always_ff @(posedge clk) begin
      if (buf_we) begin
         text_mem[buf_waddr] <= buf_wdata;
      end
      rd_mem <= text_mem[rd_idx];
   end

   // The buffer itself holds no reset. This register tracks the read so that
   // the code seen by stage 2 is cleared along with the rest of the pipeline.
   logic rd_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b1;
      end
   end

   always_comb begin
      rd_code = rd_valid ? rd_mem : '0;
   end

   // ---------------------------------------------------------------------------
   // Pixel pipeline
   //   stage 1: buffer read, pixel geometry and video captured
   //   stage 2: font ROM address issued
   //   stage 3: ROM row arrives, video delayed in step
   //   output : rgb chosen and registered
   // ---------------------------------------------------------------------------
   vga_t       in_vga;
   vga_t       s1_vga;
   vga_t       s2_vga;
   vga_t       s3_vga;
   vga_t       out_vga;
   logic [3:0] s1_line;
   logic [2:0] s1_xbit;
   logic [2:0] s2_xbit;
   logic [2:0] s3_xbit;
   logic       s1_in_box;
   logic       s2_in_box;
   logic       s3_in_box;
   logic       s1_run;
   logic       s2_run;
   logic       s3_run;

   always_comb begin
      in_vga.hcount = vga_in_hcount;
      in_vga.vcount = vga_in_vcount;
      in_vga.hsync  = vga_in_hsync;
      in_vga.vsync  = vga_in_vsync;
      in_vga.hblnk  = vga_in_hblnk;
      in_vga.vblnk  = vga_in_vblnk;
      in_vga.rgb    = vga_in_rgb;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vga    <= '0;
         s1_line   <= '0;
         s1_xbit   <= '0;
         s1_in_box <= 1'b0;
         s1_run    <= 1'b0;
         s2_vga    <= '0;
         s2_xbit   <= '0;
         s2_in_box <= 1'b0;
         s2_run    <= 1'b0;
         char_addr <= '0;
         s3_vga    <= '0;
         s3_xbit   <= '0;
         s3_in_box <= 1'b0;
         s3_run    <= 1'b0;
      end else begin
         s1_vga    <= in_vga;
         s1_line   <= line;
         s1_xbit   <= xbit;
         s1_in_box <= in_box;
         s1_run    <= run;

         s2_vga    <= s1_vga;
         s2_xbit   <= s1_xbit;
         s2_in_box <= s1_in_box;
         s2_run    <= s1_run;
         char_addr <= s1_in_box ? {rd_code, s1_line} : '0;

         s3_vga    <= s2_vga;
         s3_xbit   <= s2_xbit;
         s3_in_box <= s2_in_box;
         s3_run    <= s2_run;
      end
   end

   // The overlay is gated by the FSM state at the moment the pixel entered
   // the pipeline, so a pixel sampled during the clear is never drawn.
   logic       pix_on;
   logic       blank;
   logic [11:0] rgb_next;

   always_comb begin
      pix_on   = char_pixels[3'd7 - s3_xbit];
      blank    = s3_vga.hblnk | s3_vga.vblnk;
      rgb_next = s3_vga.rgb;
      if (s3_in_box && s3_run && !blank && pix_on) begin
         rgb_next = FG_COLOR;
      end else if (s3_in_box && s3_run && BG_EN && !blank) begin
         rgb_next = BG_COLOR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vga <= '0;
      end else begin
         out_vga     <= s3_vga;
         out_vga.rgb <= rgb_next;
      end
   end

   always_comb begin
      vga_out_hcount = out_vga.hcount;
      vga_out_vcount = out_vga.vcount;
      vga_out_hsync  = out_vga.hsync;
      vga_out_vsync  = out_vga.vsync;
      vga_out_hblnk  = out_vga.hblnk;
      vga_out_vblnk  = out_vga.vblnk;
      vga_out_rgb    = out_vga.rgb;
   end

endmodule
